// File: rtl/mux_rr_nto1.sv
// Registered N-to-1 channel multiplexer with per-channel valid/ready.
// Channel selection is either an explicit index (i_mode=0) or round-robin
// over requesting channels (i_mode=1). The output is a single registered
// stage. It reloads whenever it is empty or being drained in the same cycle,
// so back-to-back transfers run without bubbles.
module mux_rr_nto1 #(
  parameter int N    = 4,
  parameter int W    = 4,
  parameter int SELW = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_mode,
  input  logic [SELW-1:0] i_select,
  input  logic [N*W-1:0]  i_in_data,
  input  logic [N-1:0]    i_in_valid,
  output logic [N-1:0]    o_in_ready,
  output logic [W-1:0]    o_out_data,
  output logic [SELW-1:0] o_out_chan,
  output logic            o_out_valid,
  input  logic            i_out_ready
);

  logic [W-1:0]    r_out_data;
  logic [SELW-1:0] r_out_chan;
  logic            r_out_valid;
  logic [SELW-1:0] r_last_grant;

  logic            w_load;
  logic            w_sel_hit;
  logic            w_rr_valid;
  logic [SELW-1:0] w_rr_chan;
  logic [SELW:0]   w_rr_sum;
  logic            w_grant_valid;
  logic [SELW-1:0] w_grant_chan;
  logic [W-1:0]    w_grant_data;
  logic            w_xfer;

  // The output stage can take new data when empty or drained this cycle.
  assign w_load = ~r_out_valid | i_out_ready;

  // Explicit select: only an in-range index that matches a real channel can
  // hit. An out-of-range select matches no loop index, so it never grants.
  always_comb begin
    w_sel_hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (i_select == SELW'(i)) begin
        w_sel_hit = i_in_valid[i];
      end
    end
  end

  // Round-robin search: try last_grant+1, +2, ... modulo N.
  // The first requesting channel found wins.
  always_comb begin
    w_rr_valid = 1'b0;
    w_rr_chan  = '0;
    w_rr_sum   = '0;
    for (int k = 1; k <= N; k++) begin
      w_rr_sum = {1'b0, r_last_grant} + (SELW+1)'(k);
      if (w_rr_sum >= (SELW+1)'(N)) begin
        w_rr_sum = w_rr_sum - (SELW+1)'(N);
      end
      for (int i = 0; i < N; i++) begin
        if (!w_rr_valid && (w_rr_sum[SELW-1:0] == SELW'(i)) && i_in_valid[i]) begin
          w_rr_valid = 1'b1;
          w_rr_chan  = SELW'(i);
        end
      end
    end
  end

  // Pick the grant source for the current mode.
  always_comb begin
    if (i_mode) begin
      w_grant_valid = w_rr_valid;
      w_grant_chan  = w_rr_chan;
    end else begin
      w_grant_valid = w_sel_hit;
      w_grant_chan  = i_select;
    end
  end

  // Data mux for the granted channel. Indices past N-1 select nothing.
  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_chan == SELW'(i)) begin
        w_grant_data = i_in_data[i*W +: W];
      end
    end
  end

  // One-hot accept back to the producers. Accept is forced low during reset
  // so no handshake completes in a reset cycle.
  always_comb begin
    o_in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant_chan == SELW'(i)) begin
        o_in_ready[i] = ~i_rst & w_load & w_grant_valid;
      end
    end
  end

  assign w_xfer = ~i_rst & w_load & w_grant_valid;

  // Output register and round-robin pointer. Reset leaves last_grant at N-1,
  // so the first round-robin search starts at channel 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_chan   <= '0;
      r_last_grant <= SELW'(N-1);
    end else if (w_xfer) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= w_grant_data;
      r_out_chan   <= w_grant_chan;
      r_last_grant <= w_grant_chan;
    end else if (i_out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_chan  = r_out_chan;
  assign o_out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_rr_nto1.sv
// Testbench for mux_rr_nto1 (N=4, W=4).
module tb_mux_rr_nto1;
  localparam int N    = 4;
  localparam int W    = 4;
  localparam int SELW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            mode;
  logic [SELW-1:0] select;
  logic [N*W-1:0]  in_data;
  logic [N-1:0]    in_valid;
  logic [N-1:0]    in_ready;
  logic [W-1:0]    out_data;
  logic [SELW-1:0] out_chan;
  logic            out_valid;
  logic            out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_nto1 #(.N(N), .W(W), .SELW(SELW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_mode(mode),
    .i_select(select),
    .i_in_data(in_data),
    .i_in_valid(in_valid),
    .o_in_ready(in_ready),
    .o_out_data(out_data),
    .o_out_chan(out_chan),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic            rst;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [N*W-1:0]  data;
    logic [N-1:0]    valid;
    logic            ordy;
    logic [N-1:0]    exp_rdy;
    logic            exp_v;
    logic [W-1:0]    exp_d;
    logic [SELW-1:0] exp_c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic m, logic [SELW-1:0] s, logic [N*W-1:0] d,
                              logic [N-1:0] v, logic o, logic [N-1:0] er,
                              logic ev, logic [W-1:0] ed, logic [SELW-1:0] ec);
    vec_t t;
    t.rst = r; t.mode = m; t.sel = s; t.data = d; t.valid = v; t.ordy = o;
    t.exp_rdy = er; t.exp_v = ev; t.exp_d = ed; t.exp_c = ec;
    return t;
  endfunction

  // Behavioural reference state
  int m_v, m_d, m_c, m_last;

  function automatic int model_grant(input logic md, input int sel, input logic [N-1:0] v,
                                     input int last);
    if (md == 1'b0) begin
      if (sel < N && v[sel]) return sel;
      return -1;
    end
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  initial begin
    int g;
    logic [N-1:0] exp_rdy;
    rst = 1'b1; mode = 0; select = 0; in_data = 0; in_valid = 0; out_ready = 0;

    //          rst mode sel data      valid    ordy rdy      v  d     c
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 2, 16'hDCBA, 4'b0100, 1, 4'b0100, 1, 4'hC, 2));
    vecs.push_back(mk(0, 0, 2, 16'hDCBA, 4'b0000, 1, 4'b0000, 0, 4'hC, 2));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 4'b0000, 0, 4'b0000, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 1, 4'b0001, 1, 4'h1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 1, 4'b0010, 1, 4'h2, 1));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 1));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 1));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 0, 4'b0000, 1, 4'h2, 1));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 1, 4'b0100, 1, 4'h3, 2));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 1, 4'b1000, 1, 4'h4, 3));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1111, 1, 4'b0001, 1, 4'h1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1001, 1, 4'b1000, 1, 4'h4, 3));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1001, 1, 4'b0001, 1, 4'h1, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1001, 1, 4'b1000, 1, 4'h4, 3));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b1001, 1, 4'b0001, 1, 4'h1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h4321, 4'b1101, 1, 4'b0000, 0, 4'h1, 0));
    vecs.push_back(mk(0, 0, 1, 16'h4321, 4'b1101, 1, 4'b0000, 0, 4'h1, 0));
    vecs.push_back(mk(0, 0, 3, 16'h4321, 4'b1000, 1, 4'b1000, 1, 4'h4, 3));
    vecs.push_back(mk(0, 0, 3, 16'h4321, 4'b1000, 0, 4'b0000, 1, 4'h4, 3));
    vecs.push_back(mk(1, 0, 3, 16'h4321, 4'b1000, 0, 4'b0000, 0, 4'h0, 0));
    vecs.push_back(mk(0, 1, 0, 16'h4321, 4'b0110, 0, 4'b0010, 1, 4'h2, 1));

    @(posedge clk); #1;
    foreach (vecs[i]) begin
      rst = vecs[i].rst; mode = vecs[i].mode; select = vecs[i].sel;
      in_data = vecs[i].data; in_valid = vecs[i].valid; out_ready = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
      @(posedge clk); #1;
      chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_v));
      chk($sformatf("vec%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_d));
      chk($sformatf("vec%0d out_chan", i), 32'(out_chan), 32'(vecs[i].exp_c));
    end

    // Randomized traffic against the reference model, starting from reset.
    m_v = 0; m_d = 0; m_c = 0; m_last = N-1;
    rst = 1'b1; in_valid = 0; out_ready = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      select    = SELW'($urandom_range(0, N-1));
      in_data   = (N*W)'($urandom);
      in_valid  = N'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      g = model_grant(mode, int'(select), in_valid, m_last);
      exp_rdy = '0;
      if (!rst && (m_v == 0 || out_ready) && g >= 0) exp_rdy[g] = 1'b1;
      @(negedge clk);
      chk("rand in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rand out_valid", 32'(out_valid), 32'(m_v));
      chk("rand out_data", 32'(out_data), 32'(m_d));
      chk("rand out_chan", 32'(out_chan), 32'(m_c));
      @(posedge clk);
      if (rst) begin
        m_v = 0; m_d = 0; m_c = 0; m_last = N-1;
      end else if (exp_rdy != 0) begin
        m_v = 1; m_d = int'(in_data[g*W +: W]); m_c = g; m_last = g;
      end else if (out_ready) begin
        m_v = 0;
      end
      #1;
    end
    @(negedge clk);
    chk("final out_valid", 32'(out_valid), 32'(m_v));
    chk("final out_data", 32'(out_data), 32'(m_d));
    chk("final out_chan", 32'(out_chan), 32'(m_c));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
